fetch_prefetch_unit: RTL

- Instruction fetch front-end feeding the decode stage of CPU_pipeline.
- Issues in-order word requests to instruction memory through a req/gnt/rvalid handshake.
- Buffers returned instructions with their PCs in a small prefetch FIFO.
- Supplies one instruction per cycle to decode, honouring decode stall and branch/jump redirects from execute.

---
 rtl/fetch_prefetch_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front-end: issues in-order word requests to instruction
// memory, buffers responses with their PCs and hands one per cycle to decode.
module fetch_prefetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [31:0]   BOOT_PC  = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   resp_pc, resp_pc_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [CW-1:0] discard, discard_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW:0]   credit_sum;
  logic [31:0]   target_pc;
  logic          accept, rsp, push, pop, redirect;

  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem    [FIFO_DEPTH];

  // Credit rule: buffered plus in-flight never exceeds the FIFO, so every
  // response is guaranteed a slot and no back-pressure to memory is needed.
  always_comb begin
    credit_sum = {1'b0, count} + {1'b0, outstanding};
    imem_req   = (state == FETCH) && (credit_sum < {1'b0, DEPTH_C});
    imem_addr  = fetch_pc;
    accept     = imem_req && imem_gnt;
    rsp        = imem_rvalid && (outstanding != '0);
    redirect   = redirect_valid && (state != BOOT);
    target_pc  = redirect_pc & ~32'h3;
    push       = rsp && (state == FETCH) && !redirect;
    pop        = (count != '0) && !stall;
  end

  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    resp_pc_nxt     = resp_pc;
    discard_nxt     = discard;
    outstanding_nxt = outstanding + CW'(accept) - CW'(rsp);
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        if (accept) fetch_pc_nxt = fetch_pc + 32'd4;
        if (push)   resp_pc_nxt  = resp_pc + 32'd4;
        if (redirect) begin
          // Everything still in flight after this edge belongs to the old path.
          fetch_pc_nxt = target_pc;
          resp_pc_nxt  = target_pc;
          discard_nxt  = outstanding_nxt;
          state_nxt    = (outstanding_nxt != '0) ? DRAIN : FETCH;
        end
      end
      DRAIN: begin
        if (rsp && (discard != '0)) discard_nxt = discard - CW'(1);
        if (redirect) begin
          fetch_pc_nxt = target_pc;
          resp_pc_nxt  = target_pc;
        end
        if (discard_nxt == '0) state_nxt = FETCH;
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      fetch_pc    <= BOOT_PC;
      resp_pc     <= BOOT_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      resp_pc     <= resp_pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      if (redirect) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= resp_pc;
    end
  end

  always_comb begin
    if_valid = (count != '0);
    if_instr = if_valid ? instr_mem[rd_ptr] : NOP_INSTR;
    if_pc    = if_valid ? pc_mem[rd_ptr]    : 32'h0;
  end

  rvalid_without_request : assert property (
    @(posedge clk) disable iff (!reset) !(imem_rvalid && (outstanding == '0)));

endmodule
